vga_axi_burst_fetch: RTL

AXI4 burst read master that streams one frame of pixel words from the frame buffer into a local prefetch FIFO for the VGA pixel pipeline. Generalises the single-beat VGA memory controller: configurable burst length, frame size, base address and FIFO depth, with an underrun flag and mid-frame restart handling. Sits between the memory interconnect (AXI4 read channels) and the pixel output stage, which pops one word per request.

---
 rtl/vga_fetch_pkg.sv | 24 ++
 rtl/vga_sync_fifo.sv | 62 ++++++
 rtl/vga_axi_burst_fetch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and AXI constants for the VGA frame-buffer burst fetcher.
package vga_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fetch_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_ARPROT_DEF = 3'b001;

  // AXI size encoding: log2 of the bytes per beat
  function automatic logic [2:0] axi_arsize(input int unsigned data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Show-ahead synchronous FIFO with flush and occupancy count.
module vga_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/vga_axi_burst_fetch.sv
// AXI4 burst read master filling the VGA pixel prefetch FIFO, one frame per start.
// Optional underrun counter enabled by defining VGA_FETCH_UNDERRUN_CNT_EN.
module vga_axi_burst_fetch
  import vga_fetch_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned FRAME_WORDS    = 38400,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned FIFO_DEPTH     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start_i,
  input  logic                      pxl_rd_i,
  output logic [AXI_DATA_WIDTH-1:0] pxl_data_o,
  output logic                      pxl_valid_o,
  output logic                      underrun_o,
  output logic                      rresp_err_o,
  output logic [15:0]               underrun_cnt_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [7:0]                m_arlen_o,
  output logic [2:0]                m_arsize_o,
  output logic [1:0]                m_arburst_o,
  output logic [2:0]                m_arprot_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [AXI_DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o
);

  localparam int unsigned AW    = AXI_ADDR_WIDTH;
  localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned RW    = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state_q;
  logic          active_q;
  logic          restart_pend_q;
  logic [RW-1:0] remaining_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    arlen_q;
  logic          arvalid_q;
  logic          rready_q;
  logic          underrun_q;
  logic          rresp_err_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  logic          fifo_flush_c;
  logic          fifo_push_c;
  logic          beat_c;
  logic          discard_c;
  logic          start_now_c;
  logic          space_ok_c;
  logic [31:0]   rem32_c;
  logic [31:0]   beats32_c;
  logic [7:0]    arlen_d;
  logic [31:0]   burst_beats_c;

  // Frame-start actions are applied only from IDLE, immediately or once a restart drains
  assign start_now_c  = (state_q == IDLE) && (frame_start_i || restart_pend_q);
  assign beat_c       = m_rvalid_i && rready_q;
  assign discard_c    = restart_pend_q || frame_start_i;
  assign fifo_flush_c = start_now_c;
  assign fifo_push_c  = beat_c && !discard_c;

  assign space_ok_c    = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= BURST_LEN;
  assign rem32_c       = 32'(remaining_q);
  assign beats32_c     = (rem32_c > BURST_LEN) ? BURST_LEN : rem32_c;
  assign arlen_d       = 8'(beats32_c - 32'd1);
  assign burst_beats_c = 32'(arlen_q) + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      active_q       <= 1'b0;
      restart_pend_q <= 1'b0;
      remaining_q    <= '0;
      addr_q         <= AW'(BASE_ADDR);
      arlen_q        <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_now_c) begin
            active_q       <= 1'b1;
            restart_pend_q <= 1'b0;
            remaining_q    <= RW'(FRAME_WORDS);
            addr_q         <= AW'(BASE_ADDR);
          end else if (active_q && (remaining_q != '0) && space_ok_c) begin
            state_q   <= ADDR;
            arvalid_q <= 1'b1;
            arlen_q   <= arlen_d;
          end
        end
        ADDR: begin
          if (frame_start_i) restart_pend_q <= 1'b1;
          if (m_arready_i) begin
            state_q     <= DATA;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b1;
            addr_q      <= addr_q + AW'(burst_beats_c * BYTES);
            remaining_q <= remaining_q - RW'(burst_beats_c);
          end
        end
        DATA: begin
          if (frame_start_i) restart_pend_q <= 1'b1;
          if (beat_c && m_rlast_i) begin
            state_q  <= IDLE;
            rready_q <= 1'b0;
            if (remaining_q == '0) active_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Error flag ignores beats of a burst being drained for a restart
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q  <= 1'b0;
      rresp_err_q <= 1'b0;
    end else begin
      underrun_q <= pxl_rd_i && !fifo_valid;
      if (frame_start_i) begin
        rresp_err_q <= 1'b0;
      end else if (fifo_push_c && (m_rresp_i != AXI_RESP_OKAY)) begin
        rresp_err_q <= 1'b1;
      end
    end
  end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ur_cnt_q <= '0;
    end else if (frame_start_i) begin
      ur_cnt_q <= '0;
    end else if (underrun_q && (ur_cnt_q != 16'hFFFF)) begin
      ur_cnt_q <= ur_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt_o = ur_cnt_q;
`else
  assign underrun_cnt_o = 16'h0;
`endif

  vga_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifo_flush_c),
    .push_i  (fifo_push_c),
    .data_i  (m_rdata_i),
    .pop_i   (pxl_rd_i),
    .data_o  (pxl_data_o),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign pxl_valid_o = fifo_valid;
  assign underrun_o  = underrun_q;
  assign rresp_err_o = rresp_err_q;
  assign m_araddr_o  = addr_q;
  assign m_arlen_o   = arlen_q;
  assign m_arvalid_o = arvalid_q;
  assign m_rready_o  = rready_q;
  assign m_arsize_o  = axi_arsize(AXI_DATA_WIDTH);
  assign m_arburst_o = AXI_BURST_INCR;
  assign m_arprot_o  = AXI_ARPROT_DEF;

endmodule
